ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (RD1/RD2 operands, ALU op decode).
- Executes MULT, MULTU, DIV and DIVU in radix-2 over 32 iterations and owns the architectural HI/LO registers. Also services MTHI/MTLO writes.
- Raises Busy so the hazard unit stalls IF/ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  request an operation; sampled only in IDLE.
- Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  input  WIDTH  rs operand (multiplicand or dividend).
- B  input  WIDTH  rt operand (multiplier or divisor).
- Abort  input  1  cancel the in-flight operation (branch/exception flush).
- HiWrite  input  1  MTHI.
- LoWrite  input  1  MTLO.
- WrData  input  WIDTH  data for MTHI/MTLO.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.
- Busy  output  1  high whenever state is not IDLE (combinational from state).
- Done  output  1  one-cycle registered pulse after HI/LO are updated by an operation.

Behaviour:
- Reset (async, any state): state=IDLE, Hi=0, Lo=0, Done=0, iteration counter=0, internal operand registers=0.
- States: IDLE, CALC, FIX.
- IDLE, Start=1 on edge E0:
  - Latch |A| and |B| for signed ops (raw values for unsigned).
  - Latch sign flags: product/quotient sign = A[31]^B[31]; remainder sign = A[31]; both 0 for unsigned.
  - Latch Op; clear counter; go to CALC.
- CALC: one shift-add (multiply) or shift-subtract restoring step (divide) per edge. Counter increments each edge. After ITER edges (E1..E32), go to FIX.
- FIX (edge E33):
  - Apply sign correction (two's-complement negate where the flag is set).
  - Multiply: Hi = upper half of 64-bit product, Lo = lower half.
  - Divide: Lo = quotient, Hi = remainder.
  - Set Done=1 for the following cycle; go to IDLE.
- Latency: Busy is high from after E0 to E33 (33 cycles). Hi/Lo hold the new values after E33. Done is high during cycle 34 only.
- Abort=1 in CALC or FIX: return to IDLE on that edge. Hi/Lo are not written and Done stays 0. Abort in IDLE has no effect.
- Start while Busy: ignored; the hazard unit must hold the instruction.
- HiWrite/LoWrite:
  - In IDLE, Hi/Lo take WrData on the edge; both may write in the same edge.
  - Ignored while Busy.
  - If Start=1 in the same IDLE cycle, Start wins and the writes are dropped.
- Hi/Lo hold their values whenever neither FIX nor a permitted MTHI/MTLO write occurs. Done=0 except as stated.
- Divide by zero (B=0, signed or unsigned): Lo=0xFFFFFFFF, Hi=A (the original dividend, sign preserved). Same 33-cycle latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No trap.
- Operands are captured at E0; later changes on A, B or Op do not affect the result.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD (-3), B=7 -> after 33 Busy cycles, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Done pulses once, Busy low.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Then DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000064. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI 0x1234 and MTLO 0x5678 in IDLE -> Hi=0x1234, Lo=0x5678. Repeat with Start asserted in the same cycle -> writes dropped, operation result overwrites. HiWrite during Busy -> no change.
- Start MULT 5*6, assert Abort at cycle 10 -> Busy low next cycle, Hi/Lo unchanged, Done never pulses.
- Start DIV, assert Rst asynchronously mid-CALC -> Busy, Done, Hi and Lo all 0 immediately. A new Start after reset release completes correctly. A Start pulsed while Busy is ignored.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Operand/control bundle between the ID/EX stage and the iterative multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, abort, hi_write, lo_write, wr_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, abort, hi_write, lo_write, wr_data,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Signed operations run on magnitudes; signs are restored in the FIX cycle.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic              clk,
    input  logic              rst,
    ex_muldiv_unit_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   upper_q, upper_d;   // product high half / partial remainder
    logic [WIDTH-1:0]   lower_q, lower_d;   // multiplier / dividend, becomes product low / quotient
    logic [WIDTH-1:0]   dsr_q, dsr_d;       // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic               qsign_q, qsign_d;   // product or quotient sign
    logic               rsign_q, rsign_d;   // remainder sign
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_signed;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            upper_q  <= '0;
            lower_q  <= '0;
            dsr_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            upper_q  <= upper_d;
            lower_q  <= lower_d;
            dsr_q    <= dsr_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Next-state, iteration step and HI/LO update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        upper_d   = upper_q;
        lower_d   = lower_q;
        dsr_d     = dsr_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        is_signed = ~bus.op[0];
        a_abs     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_abs     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum   = {1'b0, upper_q} + (lower_q[0] ? {1'b0, dsr_q} : {(WIDTH+1){1'b0}});
        rem_sh    = {upper_q, lower_q[WIDTH-1]};
        rem_diff  = rem_sh[WIDTH-1:0] - dsr_q;
        prod_fix  = qsign_q ? -{upper_q, lower_q} : {upper_q, lower_q};
        quo_fix   = qsign_q ? -lower_q : lower_q;
        rem_fix   = rsign_q ? -upper_q : upper_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    upper_d  = '0;
                    lower_d  = a_abs;
                    dsr_d    = b_abs;
                    is_div_d = bus.op[1];
                    div0_d   = bus.op[1] && (bus.b == '0);
                    qsign_d  = is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    rsign_d  = is_signed && bus.a[WIDTH-1];
                    cnt_d    = '0;
                    state_d  = CALC;
                end else begin
                    if (bus.hi_write) hi_d = bus.wr_data;
                    if (bus.lo_write) lo_d = bus.wr_data;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        // Restoring step; divisor 0 yields all-ones quotient and |A| remainder
                        if (rem_sh >= {1'b0, dsr_q}) begin
                            upper_d = rem_diff;
                            lower_d = {lower_q[WIDTH-2:0], 1'b1};
                        end else begin
                            upper_d = rem_sh[WIDTH-1:0];
                            lower_d = {lower_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        upper_d = mul_sum[WIDTH:1];
                        lower_d = {mul_sum[0], lower_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.abort) begin
                    if (is_div_q) begin
                        lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table plus hand-written multi-cycle sequences.
module tb_ex_muldiv_unit;
    localparam int unsigned W = 32;
    localparam int unsigned LAT = 33;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_muldiv_unit_if #(.WIDTH(W)) bus ();

    ex_muldiv_unit #(.WIDTH(W), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues the request on edge E0, then scrambles the operand inputs
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Counts Busy cycles (bounded) and checks the single Done pulse afterwards
    task automatic wait_done(input string name);
        int n;
        int early;
        n = 0;
        early = 0;
        while (bus.busy && n < 200) begin
            if (bus.done) early++;
            n++;
            tick();
        end
        check({name, " busy_cycles"}, 64'(n), 64'(LAT));
        check({name, " done_during_busy"}, 64'(early), 64'd0);
        check({name, " done_pulse"}, 64'(bus.done), 64'd1);
        tick();
        check({name, " done_clear"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int pulses;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        bus.abort = 1'b0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        bus.wr_data = '0;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{OP_DIV,   32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
        vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[8]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[10] = '{OP_MULT,  32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i));
            check($sformatf("vec%0d hi", i), 64'(bus.hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d lo", i), 64'(bus.lo), 64'(vecs[i].lo));
        end

        // MTHI then MTLO, then both on one edge
        bus.hi_write = 1'b1; bus.wr_data = 32'h0000_1234; tick();
        bus.hi_write = 1'b0; bus.lo_write = 1'b1; bus.wr_data = 32'h0000_5678; tick();
        bus.lo_write = 1'b0;
        check("mthi hi", 64'(bus.hi), 64'h1234);
        check("mtlo lo", 64'(bus.lo), 64'h5678);
        check("mt done", 64'(bus.done), 64'd0);
        bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wr_data = 32'h0000_AAAA; tick();
        bus.hi_write = 1'b0; bus.lo_write = 1'b0;
        check("mt both hi", 64'(bus.hi), 64'hAAAA);
        check("mt both lo", 64'(bus.lo), 64'hAAAA);

        // Start wins over same-cycle writes; writes and Start while busy are ignored
        bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wr_data = 32'hDEAD_0000;
        start_op(OP_MULT, 32'd5, 32'd6);
        bus.hi_write = 1'b0; bus.lo_write = 1'b0;
        check("start_wins hi", 64'(bus.hi), 64'hAAAA);
        check("start_wins lo", 64'(bus.lo), 64'hAAAA);
        tick(); tick();
        bus.hi_write = 1'b1; bus.wr_data = 32'hBEEF_BEEF; tick();
        bus.hi_write = 1'b0;
        check("busy mthi", 64'(bus.hi), 64'hAAAA);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd9; bus.b = 32'd3; tick();
        bus.start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40 && bus.busy; k++) tick();
        check("ignored start done", 64'(bus.done), 64'd1);
        check("ignored start hi", 64'(bus.hi), 64'h0);
        check("ignored start lo", 64'(bus.lo), 64'd30);
        tick();
        check("ignored start idle", 64'(bus.busy), 64'd0);

        // Abort mid-CALC
        bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wr_data = 32'h1111_2222; tick();
        bus.hi_write = 1'b0; bus.lo_write = 1'b0;
        start_op(OP_MULT, 32'd5, 32'd6);
        repeat (9) tick();
        bus.abort = 1'b1; tick();
        bus.abort = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) pulses++;
            tick();
        end
        check("abort done", 64'(pulses), 64'd0);
        check("abort hi", 64'(bus.hi), 64'h1111_2222);
        check("abort lo", 64'(bus.lo), 64'h1111_2222);

        // Abort in the FIX cycle
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (32) tick();
        check("fix busy", 64'(bus.busy), 64'd1);
        bus.abort = 1'b1; tick();
        bus.abort = 1'b0;
        check("fix abort busy", 64'(bus.busy), 64'd0);
        check("fix abort done", 64'(bus.done), 64'd0);
        check("fix abort hi", 64'(bus.hi), 64'h1111_2222);
        check("fix abort lo", 64'(bus.lo), 64'h1111_2222);

        // Abort in IDLE does not block a following operation
        bus.abort = 1'b1; tick();
        bus.abort = 1'b0;
        check("idle abort busy", 64'(bus.busy), 64'd0);
        check("idle abort hi", 64'(bus.hi), 64'h1111_2222);

        // Asynchronous reset mid-CALC, then a clean operation
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 64'(bus.busy), 64'd0);
        check("async rst done", 64'(bus.done), 64'd0);
        check("async rst hi", 64'(bus.hi), 64'd0);
        check("async rst lo", 64'(bus.lo), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_done("post_rst");
        check("post_rst hi", 64'(bus.hi), 64'd2);
        check("post_rst lo", 64'(bus.lo), 64'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
